// File: rtl/fetch_sequencer_if.sv
// Memory-read and core-handshake bundle shared by the fetch sequencer
// (master) and the memory/core side (slave).
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] instr;
  logic               core_run;
  logic               core_done;

  modport master (
    output mem_addr,
    output instr,
    output core_run,
    input  mem_data,
    input  pc_next,
    input  core_done
  );

  modport slave (
    input  mem_addr,
    input  instr,
    input  core_run,
    output mem_data,
    output pc_next,
    output core_done
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-issue instruction fetch sequencer: fetches at PC, hands the word to
// the core with a one-cycle start pulse, and waits for completion or timeout.
//
// state  | meaning
// IDLE   | waiting for run_en (or a step pulse in step mode)
// FETCH  | PC on mem_addr, waiting FETCH_WAIT cycles for memory read data
// ISSUE  | instruction latched, core_run high for this single cycle
// EXEC   | waiting for core_done, counting toward TIMEOUT
// HALTED | orderly stop, held until halt_req drops
// ERROR  | core never completed; left only by reset
module fetch_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 16,
  parameter int FETCH_WAIT = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_en,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   halt_req,
  fetch_sequencer_if.master      bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   timeout_err,
  output logic [15:0]            instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, HALTED, ERROR} state_t;

  // Both counters are loaded with (length - 1) and run down to zero.
  localparam logic [3:0]  WAIT_LOAD = 4'(FETCH_WAIT - 1);
  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT - 1);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q;
  logic               core_run_q;
  logic [3:0]         wait_cnt;
  logic [15:0]        tmo_cnt;

  assign bus.mem_addr = pc;
  assign bus.instr    = instr_q;
  assign bus.core_run = core_run_q;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_q     <= '0;
      core_run_q  <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      core_run_q <= 1'b0;
      case (state)
        IDLE: begin
          if (halt_req) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (run_en && (!step_mode || step)) begin
            state    <= FETCH;
            busy     <= 1'b1;
            wait_cnt <= WAIT_LOAD;
          end
        end
        FETCH: begin
          // Latch on the last FETCH edge so instr is valid while core_run is high.
          if (wait_cnt == 4'd0) begin
            state      <= ISSUE;
            instr_q    <= bus.mem_data;
            core_run_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ISSUE: begin
          state   <= EXEC;
          tmo_cnt <= TMO_LOAD;
        end
        EXEC: begin
          // Completion wins over a timeout reached in the same cycle.
          if (bus.core_done) begin
            pc      <= bus.pc_next;
            tmo_cnt <= '0;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            if (halt_req) begin
              state  <= HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else if (step_mode) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (run_en) begin
              state    <= FETCH;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (tmo_cnt == 16'd0) begin
            state       <= ERROR;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
